lsu_bus_master: RTL and testbench

//   Initiator side of the M-stage data-memory interface. Takes a load/store op from the

---
 rtl/lsu_bus_master_if.sv | 22 ++
 rtl/lsu_bus_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_master_if.sv
// Data-memory bus between the LSU initiator and a variable-latency memory:
// req/gnt handshake for the request phase, rvalid for returned load data.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// M-stage load/store initiator: alignment check, lane formatting, req/gnt + rvalid handshake.
// Min latency store 3 / load 4 cycles; stalls the pipeline until the memory responds or times out.
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       lsu_op,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             exc_adel,
    output logic             exc_ades,
    output logic             bus_err,
    lsu_bus_master_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        err_q;
    logic [7:0]  tcnt;

    logic        is_load;
    logic        is_store;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        accept;
    logic        timeout;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        is_half  = 1'b0;
        case (lsu_op)
            OP_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
            OP_LH, OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
            OP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
            OP_SB:          is_store = 1'b1;
            default:        ;
        endcase

        misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
        accept     = (state == IDLE) && (is_load || is_store) && !misaligned;

        // Store data is replicated across lanes so the memory only needs byte enables.
        if (is_word) begin
            be_new    = 4'b1111;
            wdata_new = wdata;
        end else if (is_half) begin
            be_new    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata[15:0]}};
        end else begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
        end
    end

    always_comb begin
        half_sel = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = bus.bus_rdata[7:0];
            2'd1:    byte_sel = bus.bus_rdata[15:8];
            2'd2:    byte_sel = bus.bus_rdata[23:16];
            default: byte_sel = bus.bus_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0000, half_sel};
            OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {24'h000000, byte_sel};
            default: load_ext = bus.bus_rdata;
        endcase
    end

    assign timeout = (tcnt == TIMEOUT_LAST);

    assign stall         = (state == REQ) || (state == WAIT) || accept;
    assign exc_adel      = (state == IDLE) && is_load && misaligned;
    assign exc_ades      = (state == IDLE) && is_store && misaligned;
    assign bus_err       = (state == RESP) && err_q;
    assign rdata_valid   = (state == RESP) && !we_q && !err_q;

    assign bus.bus_req   = (state == REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            tcnt    <= 8'd0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= REQ;
                        op_q    <= lsu_op;
                        addr_q  <= addr;
                        wdata_q <= wdata_new;
                        be_q    <= be_new;
                        we_q    <= is_store;
                        tcnt    <= 8'd0;
                    end
                end
                REQ: begin
                    // Counter saturates so a late grant still leaves the WAIT phase bounded.
                    if (!timeout) tcnt <= tcnt + 8'd1;
                    if (bus.bus_gnt) begin
                        state <= we_q ? RESP : WAIT;
                    end else if (timeout) begin
                        state <= RESP;
                        err_q <= 1'b1;
                        rdata <= 32'd0;
                    end
                end
                WAIT: begin
                    if (!timeout) tcnt <= tcnt + 8'd1;
                    if (bus.bus_rvalid) begin
                        state <= RESP;
                        rdata <= load_ext;
                    end else if (timeout) begin
                        state <= RESP;
                        err_q <= 1'b1;
                        rdata <= 32'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed + random bench for lsu_bus_master; the bench doubles as a variable-latency memory
// and compares against a byte-addressed reference memory.
module tb_lsu_bus_master;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lsu_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    lsu_bus_master_if bus ();

    lsu_bus_master dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_op      (lsu_op),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .bus_err     (bus_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] smem [256];
    logic [7:0] rmem [256];

    int          r_scyc, r_errc;
    logic        r_vld, r_req, r_adel, r_ades, r_we;
    logic [31:0] r_rd, r_addr, r_wd;
    logic [3:0]  r_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            default:          return 1;
        endcase
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            smem[{a[7:2], 2'(i)}] = w[8*i +: 8];
            rmem[{a[7:2], 2'(i)}] = w[8*i +: 8];
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns after the first non-stall cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rd);
        int reqc = 0, waitc = 0, cyc = 0;
        logic waiting = 1'b0, done = 1'b0;
        logic [5:0] widx = 6'd0;
        r_scyc = 0; r_errc = 0; r_vld = 0; r_req = 0; r_adel = 0; r_ades = 0; r_we = 0;
        r_rd = 0; r_addr = 0; r_wd = 0; r_be = 0;
        lsu_op = op; addr = a; wdata = wd;
        while (!done && cyc < 400) begin
            bus.bus_gnt    = bus.bus_req && (reqc == gd);
            bus.bus_rvalid = waiting && (waitc == rd);
            bus.bus_rdata  = bus.bus_rvalid ? {smem[{widx, 2'd3}], smem[{widx, 2'd2}],
                                               smem[{widx, 2'd1}], smem[{widx, 2'd0}]} : $urandom;
            @(negedge clk);
            if (cyc == 0) begin r_adel = exc_adel; r_ades = exc_ades; end
            if (bus.bus_req && !r_req) begin
                r_req = 1; r_addr = bus.bus_addr; r_be = bus.bus_be; r_wd = bus.bus_wdata; r_we = bus.bus_we;
            end
            if (stall) r_scyc++;
            if (rdata_valid) begin r_vld = 1; r_rd = rdata; end
            if (bus_err) r_errc++;
            if (!stall) done = 1;
            if (bus.bus_rvalid) waiting = 0;
            else if (waiting) waitc++;
            if (bus.bus_gnt) begin
                if (bus.bus_we) begin
                    for (int k = 0; k < 4; k++)
                        if (bus.bus_be[k]) smem[{bus.bus_addr[7:2], 2'(k)}] = bus.bus_wdata[8*k +: 8];
                end else begin
                    waiting = 1; waitc = 0; widx = bus.bus_addr[7:2];
                end
            end
            if (bus.bus_req) reqc++;
            @(posedge clk); #1;
            cyc++;
        end
        lsu_op = 4'd0; bus.bus_gnt = 0; bus.bus_rvalid = 0;
        if (!done) chk("cycle_budget", 32'd0, 32'd1);
    endtask

    // Reference: expectations derived from byte-level memory semantics.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rd, input string nm);
        bit ld, st, sgn, mis;
        int size, off;
        logic [3:0]  ebe;
        logic [31:0] ewd, val;
        ld   = (op >= 4'd1) && (op <= 4'd5);
        st   = (op >= 4'd6) && (op <= 4'd8);
        sgn  = (op == 4'd2) || (op == 4'd4);
        size = op_size(op);
        off  = int'(a[1:0]);
        mis  = (ld || st) && ((off % size) != 0);
        run_op(op, a, wd, gd, rd);
        if (!(ld || st) || mis) begin
            chk({nm, "_adel"}, 32'(r_adel), 32'(ld && mis));
            chk({nm, "_ades"}, 32'(r_ades), 32'(st && mis));
            chk({nm, "_stall"}, r_scyc, 0);
            chk({nm, "_req"}, 32'(r_req), 0);
        end else begin
            ebe = 4'b0000;
            for (int k = 0; k < size; k++) ebe[off + k] = 1'b1;
            chk({nm, "_addr"}, r_addr, a & 32'hFFFF_FFFC);
            chk({nm, "_be"}, 32'(r_be), 32'(ebe));
            chk({nm, "_we"}, 32'(r_we), 32'(st));
            chk({nm, "_err"}, r_errc, 0);
            chk({nm, "_stall"}, r_scyc, 1 + (gd + 1) + (ld ? rd + 1 : 0));
            if (st) begin
                for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*((k - off) & (size - 1)) +: 8];
                chk({nm, "_wdata"}, r_wd, ewd);
                chk({nm, "_vld"}, 32'(r_vld), 0);
                for (int i = 0; i < size; i++) rmem[int'(a[7:0]) + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(rmem[int'(a[7:0]) + i]) << (8*i));
                if (sgn && val[8*size - 1]) val = val | (32'hFFFF_FFFF << (8*size));
                chk({nm, "_vld"}, 32'(r_vld), 1);
                chk({nm, "_rdata"}, r_rd, val);
            end
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [7:0]  b;
        rst = 1'b1; lsu_op = 4'd0; addr = 32'd0; wdata = 32'd0;
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
        for (int i = 0; i < 256; i++) begin b = 8'($urandom); smem[i] = b; rmem[i] = b; end
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(bus.bus_req), 0);
        chk("rst_vld", 32'(rdata_valid), 0);
        chk("rst_err", 32'(bus_err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_be_we", {27'd0, bus.bus_we, bus.bus_be}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        set_word(32'h100, 32'hDEADBEEF);
        do_op(4'd1, 32'h0000_0100, 32'd0, 0, 1, "lw_dir");
        chk("lw_dir_value", r_rd, 32'hDEADBEEF);
        set_word(32'h100, 32'h80112233);
        do_op(4'd4, 32'h0000_0103, 32'd0, 1, 0, "lb_dir");
        chk("lb_dir_value", r_rd, 32'hFFFFFF80);
        do_op(4'd5, 32'h0000_0103, 32'd0, 0, 2, "lbu_dir");
        chk("lbu_dir_value", r_rd, 32'h00000080);
        do_op(4'd7, 32'h0000_0206, 32'h1234ABCD, 0, 0, "sh_dir");
        chk("sh_dir_wdata", r_wd, 32'hABCDABCD);
        do_op(4'd6, 32'h0000_0101, 32'h55AA55AA, 0, 0, "sw_mis");
        do_op(4'd2, 32'h0000_0003, 32'd0, 0, 0, "lh_mis");
        do_op(4'd11, 32'h0000_0040, 32'd0, 0, 0, "op_none");

        // Grant never arrives: abort after the full timeout window.
        run_op(4'd1, 32'h0000_0040, 32'd0, 1000, 0);
        chk("to_err_pulse", r_errc, 1);
        chk("to_vld", 32'(r_vld), 0);
        chk("to_stall", r_scyc, 256);
        // Grant on the expiry cycle, then rvalid on the saturated count: both win.
        do_op(4'd1, 32'h0000_0080, 32'd0, 254, 0, "late_gnt");

        // Async reset while waiting for read data.
        lsu_op = 4'd1; addr = 32'h0000_0044;
        @(posedge clk); #1; bus.bus_gnt = 1'b1;
        @(posedge clk); #1; bus.bus_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 1);
        rst = 1'b1; lsu_op = 4'd0;
        #1;
        chk("arst_stall", 32'(stall), 0);
        chk("arst_req", 32'(bus.bus_req), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_rvalid_vld", 32'(rdata_valid), 0);
        chk("late_rvalid_stall", 32'(stall), 0);
        @(posedge clk); #1; bus.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_vld2", 32'(rdata_valid), 0);
        chk("late_rvalid_rdata", rdata, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
            else op = 4'($urandom_range(1, 8));
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = a[1:0] & 2'(4 - op_size(op));
            do_op(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
